// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: polarity fix, 2-FF sync, debounce, press/release pulses.
// Optional auto-repeat of press pulses is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int               N_BTN           = 4,
  parameter logic [N_BTN-1:0] ACTIVE_LOW      = 4'b1001,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_In,
  output logic [N_BTN-1:0] Btn_Level,
  output logic [N_BTN-1:0] Btn_Press,
  output logic [N_BTN-1:0] Btn_Release
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [CW-1:0]    db_cnt [N_BTN];
  logic [N_BTN-1:0] level_next;
  logic [N_BTN-1:0] rpt_fire;

  always_comb begin
    level_next = Btn_Level;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync_q2[i] != Btn_Level[i] && db_cnt[i] == DB_LAST)
        level_next[i] = sync_q2[i];
    end
  end

  // Counter restarts whenever the synced input agrees with the level or the level just flipped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q1     <= '0;
      sync_q2     <= '0;
      Btn_Level   <= '0;
      Btn_Press   <= '0;
      Btn_Release <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync_q1     <= Btn_In ^ ACTIVE_LOW;
      sync_q2     <= sync_q1;
      Btn_Level   <= level_next;
      Btn_Press   <= (~Btn_Level & level_next) | rpt_fire;
      Btn_Release <= Btn_Level & ~level_next;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_q2[i] == Btn_Level[i] || db_cnt[i] == DB_LAST)
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + CW'(1);
      end
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RD_LOAD = RW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
  localparam logic [RW-1:0] RP_LOAD = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic [RW-1:0] rpt_cnt [N_BTN];

  // A repeat fires only while the level stays high, so the release cycle never pulses.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_fire[i] = REPEAT_MASK[i] & Btn_Level[i] & level_next[i] & (rpt_cnt[i] == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_BTN; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!REPEAT_MASK[i] || !level_next[i])
          rpt_cnt[i] <= '0;
        else if (!Btn_Level[i])
          rpt_cnt[i] <= RD_LOAD;
        else if (rpt_cnt[i] == '0)
          rpt_cnt[i] <= RP_LOAD;
        else
          rpt_cnt[i] <= rpt_cnt[i] - RW'(1);
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (small debounce/repeat parameters).
// Auto-repeat expectations follow BUTTON_AUTOREPEAT_EN.
module tb_button_conditioner;

  logic       Clk;
  logic       Reset;
  logic [3:0] Btn_In;
  logic [3:0] Btn_Level;
  logic [3:0] Btn_Press;
  logic [3:0] Btn_Release;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN(4), .ACTIVE_LOW(4'b1001), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .REPEAT_MASK(4'b0100)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Btn_In(Btn_In),
    .Btn_Level(Btn_Level), .Btn_Press(Btn_Press), .Btn_Release(Btn_Release)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic [11:0] outs_or;
  logic [31:0] hist1, hist2, rel2;
  int          first_press, press_cnt;
  logic [31:0] exp_hist2;

  initial begin
    Reset  = 1'b1;
    Btn_In = 4'b1001;
    tick(3);
    Reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      check_val("idle_outs", {20'd0, Btn_Level, Btn_Press, Btn_Release}, 32'd0);
      tick();
    end

    // 2: press and release on channel 1
    Btn_In[1] = 1'b1;
    tick(5);
    check_val("t2_level_k5", {28'd0, Btn_Level}, 32'h0);
    tick();
    check_val("t2_level_k6", {28'd0, Btn_Level}, 32'h2);
    check_val("t2_press_k6", {28'd0, Btn_Press}, 32'h2);
    tick();
    check_val("t2_press_k7", {28'd0, Btn_Press}, 32'h0);
    check_val("t2_level_k7", {28'd0, Btn_Level}, 32'h2);
    Btn_In[1] = 1'b0;
    tick(5);
    check_val("t2_rel_r5", {28'd0, Btn_Release}, 32'h0);
    check_val("t2_lvl_r5", {28'd0, Btn_Level}, 32'h2);
    tick();
    check_val("t2_rel_r6", {28'd0, Btn_Release}, 32'h2);
    check_val("t2_lvl_r6", {28'd0, Btn_Level}, 32'h0);
    check_val("t2_prs_r6", {28'd0, Btn_Press}, 32'h0);
    tick();
    check_val("t2_rel_r7", {28'd0, Btn_Release}, 32'h0);

    // 3: bouncing channel 2, then settles high
    outs_or = '0;
    for (int i = 0; i < 4; i++) begin
      Btn_In[2] = (i % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick();
        outs_or |= {Btn_Level, Btn_Press, Btn_Release};
      end
    end
    check_val("t3_bounce_quiet", {20'd0, outs_or}, 32'd0);
    Btn_In[2] = 1'b1;
    first_press = -1;
    press_cnt   = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (Btn_Press[2]) begin
        press_cnt++;
        if (first_press < 0) first_press = j;
      end
    end
    check_val("t3_first_press", first_press, 32'd6);
    check_val("t3_press_count", press_cnt, 32'd1);
    Btn_In[2] = 1'b0;
    tick(12);
    check_val("t3_released", {28'd0, Btn_Level}, 32'h0);

    // 4: glitch too short to qualify
    outs_or = '0;
    Btn_In[1] = 1'b1;
    tick(3);
    outs_or |= {Btn_Level, Btn_Press, Btn_Release};
    Btn_In[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      outs_or |= {Btn_Level, Btn_Press, Btn_Release};
    end
    check_val("t4_glitch_quiet", {20'd0, outs_or}, 32'd0);

    // 5: two active-low channels pressed together
    Btn_In = 4'b0000;
    tick(5);
    check_val("t5_press_k5", {28'd0, Btn_Press}, 32'h0);
    tick();
    check_val("t5_press_k6", {28'd0, Btn_Press}, 32'h9);
    check_val("t5_level_k6", {28'd0, Btn_Level}, 32'h9);
    tick();
    check_val("t5_press_k7", {28'd0, Btn_Press}, 32'h0);
    Btn_In = 4'b1001;
    tick(6);
    check_val("t5_rel_r6", {28'd0, Btn_Release}, 32'h9);
    check_val("t5_lvl_r6", {28'd0, Btn_Level}, 32'h0);
    tick();
    check_val("t5_rel_r7", {28'd0, Btn_Release}, 32'h0);

    // 6: reset mid-debounce, button kept held
    Btn_In[2] = 1'b1;
    tick(4);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("t6_after_rst", {20'd0, Btn_Level, Btn_Press, Btn_Release}, 32'd0);
    tick(5);
    check_val("t6_level_r5", {28'd0, Btn_Level}, 32'h0);
    tick();
    check_val("t6_press_r6", {28'd0, Btn_Press}, 32'h4);
    check_val("t6_level_r6", {28'd0, Btn_Level}, 32'h4);
    tick();
    check_val("t6_press_r7", {28'd0, Btn_Press}, 32'h0);
    Btn_In[2] = 1'b0;
    tick(10);
    check_val("t6_released", {28'd0, Btn_Level}, 32'h0);

    // 7: hold channels 1 and 2; only channel 2 may repeat
    Btn_In[1] = 1'b1;
    Btn_In[2] = 1'b1;
    tick(6);
    check_val("t7_press_t", {28'd0, Btn_Press}, 32'h6);
    hist1 = 32'd1;
    hist2 = 32'd1;
    rel2  = 32'd0;
    for (int j = 1; j <= 21; j++) begin
      tick();
      hist1[j] = Btn_Press[1];
      hist2[j] = Btn_Press[2];
      rel2[j]  = Btn_Release[2];
      if (j == 14) begin
        Btn_In[1] = 1'b0;
        Btn_In[2] = 1'b0;
      end
    end
`ifdef BUTTON_AUTOREPEAT_EN
    exp_hist2 = 32'h0002_4901;
`else
    exp_hist2 = 32'h0000_0001;
`endif
    check_val("t7_ch2_presses", hist2, exp_hist2);
    check_val("t7_ch1_presses", hist1, 32'h0000_0001);
    check_val("t7_ch2_release", rel2, 32'h0010_0000);
    check_val("t7_level_end", {28'd0, Btn_Level}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
